// File: rtl/portb_ctrl.sv
// PORTB register controller: TRISB/latch, pin sync, RB0/INT and RB7:4 change flags.
// Optional weak pull-up control under PORTB_WEAK_PULLUP_EN.
module portb_ctrl #(
  parameter logic [7:0] PORT_ADDR   = 8'h06,
  parameter logic [7:0] TRIS_ADDR   = 8'h86,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_out,
  output logic [7:0] pin_oe,
  input  logic       intedg,
  input  logic       intf_clr,
  input  logic       rbif_clr,
  output logic       intf,
  output logic       rbif
`ifdef PORTB_WEAK_PULLUP_EN
  ,
  input  logic       rbpu_n,
  output logic [7:0] pu_en
`endif
);

  logic [7:0] trisb;
  logic [7:0] latch;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] pin_s;
  logic       prev0;
  logic [3:0] rb_ref;

  logic       port_sel;
  logic       tris_sel;
  logic       int_edge;
  logic       int_set;
  logic       rb_set;

  assign port_sel = (addr == PORT_ADDR);
  assign tris_sel = (addr == TRIS_ADDR);
  assign pin_s    = sync_q[SYNC_STAGES-1];

  assign int_edge = intedg ? (pin_s[0] & ~prev0)
                           : (~pin_s[0] & prev0);
  assign int_set  = int_edge & trisb[0];
  // only input-configured RB7:4 bits may raise the change flag
  assign rb_set   = |((pin_s[7:4] ^ rb_ref) & trisb[7:4]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trisb  <= 8'hFF;
      latch  <= 8'h00;
      prev0  <= 1'b0;
      rb_ref <= 4'h0;
      intf   <= 1'b0;
      rbif   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= 8'h00;
    end else begin
      if (wr_en && port_sel)
        latch <= wdata;
      if (wr_en && tris_sel)
        trisb <= wdata;
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev0 <= pin_s[0];
      if (rd_en && port_sel)
        rb_ref <= pin_s[7:4];
      intf <= int_set | (intf & ~intf_clr);
      rbif <= rb_set | (rbif & ~rbif_clr);
    end
  end

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      port_sel: rdata = (trisb & pin_s) | (~trisb & latch);
      tris_sel: rdata = trisb;
      default:  rdata = 8'h00;
    endcase
  end

  assign pin_out = latch;
  assign pin_oe  = ~trisb;

`ifdef PORTB_WEAK_PULLUP_EN
  assign pu_en = {8{~rbpu_n}} & trisb;
`endif

endmodule

// File: tb/tb_portb_ctrl.sv
// Self-checking bench for portb_ctrl: directed scenarios plus random
// traffic against a cycle-history reference model.
module tb_portb_ctrl;

  localparam int S = 2;
  localparam logic [7:0] PA = 8'h06;
  localparam logic [7:0] TA = 8'h86;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;
  logic       intedg;
  logic       intf_clr;
  logic       rbif_clr;
  logic       intf;
  logic       rbif;
`ifdef PORTB_WEAK_PULLUP_EN
  logic       rbpu_n;
  logic [7:0] pu_en;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  portb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
    .rdata(rdata), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe),
    .intedg(intedg), .intf_clr(intf_clr),
    .rbif_clr(rbif_clr), .intf(intf), .rbif(rbif)
`ifdef PORTB_WEAK_PULLUP_EN
    , .rbpu_n(rbpu_n), .pu_en(pu_en)
`endif
  );

  // model: samp[k] is pin_in as sampled k+1 edges ago
  logic [7:0] m_tris, m_latch;
  logic [7:0] samp [0:S];
  logic [3:0] m_ref;
  logic       m_intf, m_rbif;

  function automatic logic [7:0] m_pins();
    return samp[S-1];
  endfunction

  function automatic logic [7:0] m_rdata();
    if (addr == PA)
      return (m_tris & m_pins()) | (~m_tris & m_latch);
    if (addr == TA)
      return m_tris;
    return 8'h00;
  endfunction

  task automatic tick();
    logic [7:0] ps, pv, nt, nl;
    logic [3:0] nr;
    logic       ni, nb, edge_hit;
    ps = samp[S-1];
    pv = samp[S];
    nt = m_tris;
    nl = m_latch;
    nr = m_ref;
    if (intedg) edge_hit = ps[0] && !pv[0];
    else        edge_hit = !ps[0] && pv[0];
    ni = (edge_hit && m_tris[0]) || (m_intf && !intf_clr);
    nb = (((ps[7:4] ^ m_ref) & m_tris[7:4]) != 4'h0)
         || (m_rbif && !rbif_clr);
    if (rd_en && addr == PA) nr = ps[7:4];
    if (wr_en && addr == PA) nl = wdata;
    if (wr_en && addr == TA) nt = wdata;
    @(posedge clk);
    if (!rst_n) begin
      m_tris = 8'hFF; m_latch = 8'h00; m_ref = 4'h0;
      m_intf = 1'b0; m_rbif = 1'b0;
      for (int k = 0; k <= S; k++) samp[k] = 8'h00;
    end else begin
      m_tris = nt; m_latch = nl; m_ref = nr;
      m_intf = ni; m_rbif = nb;
      for (int k = S; k > 0; k--) samp[k] = samp[k-1];
      samp[0] = pin_in;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_port();
    addr = PA; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    addr = TA;
    #1;
    checks++;
    if (rdata !== 8'hFF) begin
      errors++;
      $display("FAIL reset_tris got=%h exp=ff", rdata);
    end
    checks++;
    if (pin_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset_oe got=%h exp=00", pin_oe);
    end
    checks++;
    if (pin_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out got=%h exp=00", pin_out);
    end
    checks++;
    if (intf !== 1'b0 || rbif !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b exp=00", intf, rbif);
    end
  endtask

  task automatic test_rw();
    wr(TA, 8'h0F);
    addr = PA; wdata = 8'hA5; wr_en = 1'b1;
    pin_in = 8'h3C;
    tick();
    wr_en = 1'b0;
    checks++;
    if (pin_oe !== 8'hF0) begin
      errors++;
      $display("FAIL rw_oe got=%h exp=f0", pin_oe);
    end
    checks++;
    if (pin_out !== 8'hA5) begin
      errors++;
      $display("FAIL rw_out got=%h exp=a5", pin_out);
    end
    tick();
    addr = PA;
    #1;
    checks++;
    if (rdata !== 8'hAC) begin
      errors++;
      $display("FAIL rw_merge got=%h exp=ac", rdata);
    end
    // same-cycle read and write returns the old latch
    wdata = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++;
    if (rdata !== 8'hAC) begin
      errors++;
      $display("FAIL rw_same_cycle got=%h exp=ac", rdata);
    end
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    checks++;
    if (rdata !== 8'h5C) begin
      errors++;
      $display("FAIL rw_after got=%h exp=5c", rdata);
    end
  endtask

  task automatic test_intedge();
    logic [2:0] seen;
    wr(TA, 8'hFF);
    intedg = 1'b1; pin_in = 8'h00; intf_clr = 1'b1;
    repeat (4) tick();
    intf_clr = 1'b0;
    pin_in = 8'h01;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen[c] = intf;
    end
    checks++;
    if (seen !== 3'b100) begin
      errors++;
      $display("FAIL intf_rise_latency got=%b exp=100", seen);
    end
    pin_in = 8'h00; intf_clr = 1'b1;
    repeat (4) tick();
    intf_clr = 1'b0; intedg = 1'b0;
    pin_in = 8'h01;
    repeat (4) tick();
    checks++;
    if (intf !== 1'b0) begin
      errors++;
      $display("FAIL intf_wrong_edge got=%b exp=0", intf);
    end
    intedg = 1'b1;
  endtask

  task automatic test_rbif();
    wr(TA, 8'hFF);
    pin_in = 8'h00;
    repeat (3) tick();
    rd_port();
    rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
    pin_in = 8'h40;
    tick(); tick();
    checks++;
    if (rbif !== 1'b0) begin
      errors++;
      $display("FAIL rbif_early got=%b exp=0", rbif);
    end
    tick();
    checks++;
    if (rbif !== 1'b1) begin
      errors++;
      $display("FAIL rbif_set got=%b exp=1", rbif);
    end
    wr(TA, 8'hBF);
    pin_in = 8'h00;
    repeat (3) tick();
    rd_port();
    rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
    pin_in = 8'h40;
    repeat (4) tick();
    checks++;
    if (rbif !== 1'b0) begin
      errors++;
      $display("FAIL rbif_masked got=%b exp=0", rbif);
    end
  endtask

  task automatic test_set_clr();
    wr(TA, 8'hFF);
    pin_in = 8'h00;
    repeat (3) tick();
    rd_port();
    rbif_clr = 1'b1;
    tick();
    pin_in = 8'h20;
    repeat (4) tick();
    checks++;
    if (rbif !== 1'b1) begin
      errors++;
      $display("FAIL rbif_set_wins got=%b exp=1", rbif);
    end
    rbif_clr = 1'b0;
    rd_port();
    rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
    checks++;
    if (rbif !== 1'b0) begin
      errors++;
      $display("FAIL rbif_clear got=%b exp=0", rbif);
    end
  endtask

  task automatic test_reset_mid();
    wr(TA, 8'hFF);
    intedg = 1'b1; pin_in = 8'h00; intf_clr = 1'b1;
    repeat (4) tick();
    intf_clr = 1'b0;
    pin_in = 8'h01;
    repeat (3) tick();
    wr(TA, 8'h00);
    checks++;
    if (intf !== 1'b1 || pin_oe !== 8'hFF) begin
      errors++;
      $display("FAIL mid_pre got=%b/%h exp=1/ff", intf, pin_oe);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    addr = TA;
    #1;
    checks++;
    if (intf !== 1'b0 || rdata !== 8'hFF) begin
      errors++;
      $display("FAIL mid_reset got=%b/%h exp=0/ff", intf, rdata);
    end
  endtask

`ifdef PORTB_WEAK_PULLUP_EN
  task automatic test_pullup();
    rbpu_n = 1'b0;
    wr(TA, 8'hF0);
    checks++;
    if (pu_en !== 8'hF0) begin
      errors++;
      $display("FAIL pullup_on got=%h exp=f0", pu_en);
    end
    rbpu_n = 1'b1;
    #1;
    checks++;
    if (pu_en !== 8'h00) begin
      errors++;
      $display("FAIL pullup_off got=%h exp=00", pu_en);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_rd;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(3))
        0: addr = PA;
        1: addr = TA;
        2: addr = PA;
        default: addr = 8'($urandom);
      endcase
      wr_en    = ($urandom_range(3) == 0);
      rd_en    = ($urandom_range(2) == 0);
      wdata    = 8'($urandom);
      intf_clr = ($urandom_range(7) == 0);
      rbif_clr = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) intedg = ~intedg;
      if ($urandom_range(2) == 0)
        pin_in = pin_in ^ (8'd1 << $urandom_range(7));
      rst_n = ($urandom_range(60) != 0);
      #1;
      exp_rd = m_rdata();
      checks++;
      if (rdata !== exp_rd) begin
        errors++;
        $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata, exp_rd);
      end
      tick();
      checks++;
      if (pin_out !== m_latch || pin_oe !== ~m_tris) begin
        errors++;
        $display("FAIL rnd_regs n=%0d got=%h/%h exp=%h/%h",
                 n, pin_out, pin_oe, m_latch, ~m_tris);
      end
      checks++;
      if (intf !== m_intf || rbif !== m_rbif) begin
        errors++;
        $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b",
                 n, intf, rbif, m_intf, m_rbif);
      end
    end
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    intf_clr = 1'b0; rbif_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    wdata = 8'h00; pin_in = 8'h00; intedg = 1'b1;
    intf_clr = 1'b0; rbif_clr = 1'b0;
`ifdef PORTB_WEAK_PULLUP_EN
    rbpu_n = 1'b1;
`endif
    m_tris = 8'hFF; m_latch = 8'h00; m_ref = 4'h0;
    m_intf = 1'b0; m_rbif = 1'b0;
    for (int k = 0; k <= S; k++) samp[k] = 8'h00;
    @(negedge clk);
    test_reset();
    test_rw();
    test_intedge();
    test_rbif();
    test_set_clr();
    test_reset_mid();
`ifdef PORTB_WEAK_PULLUP_EN
    test_pullup();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
